// File: rtl/alu_bist.sv
// Built-in self-test controller for the 32-bit lab ALU: LFSR operand generation,
// full opcode sweep per operand pair, MISR compaction and golden-signature compare.
module alu_bist #(
   parameter int unsigned N_VECTORS  = 256,
   parameter logic [31:0] SEED_A     = 32'h1234_5678,
   parameter logic [31:0] SEED_B     = 32'h8765_4321,
   parameter logic [31:0] GOLDEN_SIG = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_as,
   output logic [3:0]  alu_sro,
   output logic [3:0]  alu_lo,
   output logic [1:0]  alu_ao,
   input  logic [31:0] alu_result,
   input  logic        alu_of,
   input  logic        alu_zf,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [31:0] signature,
   output logic [15:0] vec_count
);

   localparam logic [31:0] POLY        = 32'h8020_0003;
   localparam logic [31:0] SEED_A_INIT = (SEED_A == 32'd0) ? 32'd1 : SEED_A;
   localparam logic [31:0] SEED_B_INIT = (SEED_B == 32'd0) ? 32'd1 : SEED_B;
   localparam logic [15:0] LAST_VEC    = 16'(N_VECTORS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] sig_q, sig_d;
   logic [3:0]  op_q, op_d;
   logic [15:0] cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic [31:0] misr_next;

   function automatic logic [31:0] lfsr_step(input logic [31:0] x);
      return (x >> 1) ^ (x[0] ? POLY : 32'd0);
   endfunction

   // The MISR and LFSR share the same Galois feedback polynomial.
   assign misr_next = lfsr_step(sig_q) ^ alu_result ^ {30'd0, alu_of, alu_zf};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sig_d   = sig_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               a_d     = SEED_A_INIT;
               b_d     = SEED_B_INIT;
               op_d    = 4'd0;
               sig_d   = 32'd0;
               cnt_d   = 16'd0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end
         end
         ST_RUN: begin
            sig_d = misr_next;
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == LAST_VEC) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (misr_next == GOLDEN_SIG);
            end else begin
               op_d = op_q + 4'd1;
               // Operands advance only once every opcode has seen the current pair.
               if (op_q == 4'hF) begin
                  a_d = lfsr_step(a_q);
                  b_d = lfsr_step(b_q);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= SEED_A_INIT;
         b_q     <= SEED_B_INIT;
         sig_q   <= 32'd0;
         op_q    <= 4'd0;
         cnt_q   <= 16'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sig_q   <= sig_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_as    = {2'b00, op_q[3:2]};
   assign alu_sro   = {2'b00, op_q[1:0]};
   assign alu_lo    = {2'b00, op_q[1:0]};
   assign alu_ao    = {1'b0, op_q[0]};
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign signature = sig_q;
   assign vec_count = cnt_q;

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: several parameterisations side by side, stub ALUs,
// and a high-level signature model computed from the operand/opcode sweep rules.
module tb_alu_bist;

   localparam logic [31:0] SA     = 32'h1234_5678;
   localparam logic [31:0] SB     = 32'h8765_4321;
   localparam int          MAIN_N = 256;
   localparam int          SEQ_N  = 40;

   function automatic logic [31:0] lfsr_step(input logic [31:0] x);
      return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'd0);
   endfunction

   function automatic logic [31:0] misr_step(input logic [31:0] m, input logic [31:0] r,
                                             input logic of, input logic zf);
      return lfsr_step(m) ^ r ^ {30'd0, of, zf};
   endfunction

   // Signature with a stub ALU returning A^B, OF=0, ZF=1.
   function automatic logic [31:0] ref_sig_xor(input logic [31:0] sa, input logic [31:0] sb,
                                               input int n);
      logic [31:0] a, b, m;
      a = (sa == 32'd0) ? 32'd1 : sa;
      b = (sb == 32'd0) ? 32'd1 : sb;
      m = 32'd0;
      for (int i = 0; i < n; i++) begin
         m = misr_step(m, a ^ b, 1'b0, 1'b1);
         if (i % 16 == 15) begin
            a = lfsr_step(a);
            b = lfsr_step(b);
         end
      end
      return m;
   endfunction

   // Behavioural lab ALU: unit 0 shift/rotate, 1 logic, 2 add/sub, 3 multiply.
   function automatic logic [33:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] unit, input logic [3:0] sel);
      logic [31:0] r;
      logic        of;
      of = 1'b0;
      r  = 32'hDEAD_BEEF;
      case (unit)
         4'd0: case (sel)
            4'd0: r = a << b[4:0];
            4'd1: r = a >> b[4:0];
            4'd2: r = $signed(a) >>> b[4:0];
            4'd3: r = (a << b[4:0]) | (a >> (6'd32 - {1'b0, b[4:0]}));
            default: r = 32'hDEAD_BEEF;
         endcase
         4'd1: case (sel)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a ^ b;
            4'd3: r = ~(a | b);
            default: r = 32'hDEAD_BEEF;
         endcase
         4'd2: begin
            if (sel[0]) begin
               r  = a - b;
               of = (a[31] != b[31]) && (r[31] != a[31]);
            end else begin
               r  = a + b;
               of = (a[31] == b[31]) && (r[31] != a[31]);
            end
         end
         4'd3: r = a * b;
         default: r = 32'hDEAD_BEEF;
      endcase
      return {of, (r == 32'd0), r};
   endfunction

   // Signature with the behavioural ALU, derived from the op index of each evaluation.
   function automatic logic [31:0] ref_sig_rich(input logic [31:0] sa, input logic [31:0] sb,
                                                input int n);
      logic [31:0] a, b, m;
      logic [33:0] o;
      a = sa;
      b = sb;
      m = 32'd0;
      for (int i = 0; i < n; i++) begin
         o = alu_fn(a, b, 4'((i % 16) / 4), 4'(i % 4));
         m = misr_step(m, o[31:0], o[33], o[32]);
         if (i % 16 == 15) begin
            a = lfsr_step(a);
            b = lfsr_step(b);
         end
      end
      return m;
   endfunction

   localparam logic [31:0] GOLD4 = ref_sig_xor(SA, SB, 4);

   logic       clk;
   logic       rst_n;
   logic [4:0] start_v;
   int         n_checks;
   int         n_errors;

   logic [31:0] m_a, m_b, m_res, m_sig;
   logic [3:0]  m_as, m_sro, m_lo;
   logic [1:0]  m_ao;
   logic        m_of, m_zf, m_busy, m_done, m_pass;
   logic [15:0] m_cnt;
   logic [31:0] s_a, s_b, s_sig;
   logic [3:0]  s_as, s_sro, s_lo;
   logic [1:0]  s_ao;
   logic        s_busy, s_done, s_pass;
   logic [15:0] s_cnt;
   logic [31:0] p_a, p_b, p_sig;
   logic [3:0]  p_as, p_sro, p_lo;
   logic [1:0]  p_ao;
   logic        p_busy, p_done, p_pass;
   logic [15:0] p_cnt;
   logic [31:0] f_a, f_b, f_sig;
   logic [3:0]  f_as, f_sro, f_lo;
   logic [1:0]  f_ao;
   logic        f_busy, f_done, f_pass;
   logic [15:0] f_cnt;
   logic [31:0] o_a, o_b, o_sig;
   logic [3:0]  o_as, o_sro, o_lo;
   logic [1:0]  o_ao;
   logic        o_busy, o_done, o_pass;
   logic [15:0] o_cnt;

   alu_bist #(.N_VECTORS(MAIN_N)) u_main (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]),
      .alu_a(m_a), .alu_b(m_b), .alu_as(m_as), .alu_sro(m_sro), .alu_lo(m_lo), .alu_ao(m_ao),
      .alu_result(m_res), .alu_of(m_of), .alu_zf(m_zf),
      .busy(m_busy), .done(m_done), .pass(m_pass), .signature(m_sig), .vec_count(m_cnt));

   alu_bist #(.N_VECTORS(SEQ_N), .SEED_A(32'd1)) u_seq (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]),
      .alu_a(s_a), .alu_b(s_b), .alu_as(s_as), .alu_sro(s_sro), .alu_lo(s_lo), .alu_ao(s_ao),
      .alu_result(s_a ^ s_b), .alu_of(1'b0), .alu_zf(1'b1),
      .busy(s_busy), .done(s_done), .pass(s_pass), .signature(s_sig), .vec_count(s_cnt));

   alu_bist #(.N_VECTORS(4), .GOLDEN_SIG(GOLD4)) u_n4p (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]),
      .alu_a(p_a), .alu_b(p_b), .alu_as(p_as), .alu_sro(p_sro), .alu_lo(p_lo), .alu_ao(p_ao),
      .alu_result(p_a ^ p_b), .alu_of(1'b0), .alu_zf(1'b1),
      .busy(p_busy), .done(p_done), .pass(p_pass), .signature(p_sig), .vec_count(p_cnt));

   alu_bist #(.N_VECTORS(4), .GOLDEN_SIG(GOLD4 ^ 32'd1)) u_n4f (
      .clk(clk), .rst_n(rst_n), .start(start_v[3]),
      .alu_a(f_a), .alu_b(f_b), .alu_as(f_as), .alu_sro(f_sro), .alu_lo(f_lo), .alu_ao(f_ao),
      .alu_result(f_a ^ f_b), .alu_of(1'b0), .alu_zf(1'b1),
      .busy(f_busy), .done(f_done), .pass(f_pass), .signature(f_sig), .vec_count(f_cnt));

   alu_bist #(.N_VECTORS(1)) u_n1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[4]),
      .alu_a(o_a), .alu_b(o_b), .alu_as(o_as), .alu_sro(o_sro), .alu_lo(o_lo), .alu_ao(o_ao),
      .alu_result(o_a ^ o_b), .alu_of(1'b0), .alu_zf(1'b1),
      .busy(o_busy), .done(o_done), .pass(o_pass), .signature(o_sig), .vec_count(o_cnt));

   // Stub ALU for the main instance, keyed on the decoded opcode outputs.
   always_comb begin
      logic [3:0]  sel;
      logic [33:0] o;
      sel = (m_as == 4'd1) ? m_lo : (m_as == 4'd2) ? {2'b00, m_ao} : m_sro;
      o = alu_fn(m_a, m_b, m_as, sel);
      m_res = o[31:0];
      m_zf  = o[32];
      m_of  = o[33];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] op;
      logic [3:0] as_v;
      logic [3:0] sro_v;
      logic [3:0] lo_v;
      logic [1:0] ao_v;
   } op_vec_t;

   op_vec_t tbl [16];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [4:0] mask);
      @(negedge clk);
      start_v = mask;
      @(negedge clk);
      start_v = 5'd0;
   endtask

   task automatic checkRunMain(input logic [31:0] exp_sig);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      applyStimulus(5'b00001);
      for (int c = 0; c < MAIN_N; c++) begin
         checkOutput("main_vec_count", {16'd0, m_cnt}, 32'(c));
         if (c == MAIN_N - 1) begin
            checkOutput("main_busy_last", {31'd0, m_busy}, 32'd1);
            checkOutput("main_done_early", {31'd0, m_done}, 32'd0);
         end
         start_v[0] = (c >= 1) && (c <= MAIN_N - 2) && ($urandom_range(0, 7) == 0);
         @(negedge clk);
      end
      start_v[0] = 1'b0;
      checkOutput("main_done", {31'd0, m_done}, 32'd1);
      checkOutput("main_busy_end", {31'd0, m_busy}, 32'd0);
      checkOutput("main_vec_final", {16'd0, m_cnt}, 32'(MAIN_N));
      checkOutput("main_signature", m_sig, exp_sig);
      checkOutput("main_pass", {31'd0, m_pass}, {31'd0, exp_sig == 32'd0});
      repeat (3) @(negedge clk);
      checkOutput("main_vec_hold", {16'd0, m_cnt}, 32'(MAIN_N));
      checkOutput("main_sig_hold", m_sig, exp_sig);
      checkOutput("main_done_hold", {31'd0, m_done}, 32'd1);
   endtask

   initial begin
      logic [31:0] ref_main;
      logic [31:0] ref_seq;
      logic [31:0] ref_one;
      bit          hit;
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      start_v  = 5'd0;
      tbl[0]  = '{4'd0,  4'd0, 4'd0, 4'd0, 2'd0};
      tbl[1]  = '{4'd1,  4'd0, 4'd1, 4'd1, 2'd1};
      tbl[2]  = '{4'd2,  4'd0, 4'd2, 4'd2, 2'd0};
      tbl[3]  = '{4'd3,  4'd0, 4'd3, 4'd3, 2'd1};
      tbl[4]  = '{4'd4,  4'd1, 4'd0, 4'd0, 2'd0};
      tbl[5]  = '{4'd5,  4'd1, 4'd1, 4'd1, 2'd1};
      tbl[6]  = '{4'd6,  4'd1, 4'd2, 4'd2, 2'd0};
      tbl[7]  = '{4'd7,  4'd1, 4'd3, 4'd3, 2'd1};
      tbl[8]  = '{4'd8,  4'd2, 4'd0, 4'd0, 2'd0};
      tbl[9]  = '{4'd9,  4'd2, 4'd1, 4'd1, 2'd1};
      tbl[10] = '{4'd10, 4'd2, 4'd2, 4'd2, 2'd0};
      tbl[11] = '{4'd11, 4'd2, 4'd3, 4'd3, 2'd1};
      tbl[12] = '{4'd12, 4'd3, 4'd0, 4'd0, 2'd0};
      tbl[13] = '{4'd13, 4'd3, 4'd1, 4'd1, 2'd1};
      tbl[14] = '{4'd14, 4'd3, 4'd2, 4'd2, 2'd0};
      tbl[15] = '{4'd15, 4'd3, 4'd3, 4'd3, 2'd1};
      ref_main = ref_sig_rich(SA, SB, MAIN_N);
      ref_seq  = ref_sig_xor(32'd1, SB, SEQ_N);
      ref_one  = misr_step(32'd0, SA ^ SB, 1'b0, 1'b1);

      repeat (2) @(negedge clk);
      checkOutput("rst_main_a", m_a, SA);
      checkOutput("rst_main_b", m_b, SB);
      checkOutput("rst_main_ops", {18'd0, m_as, m_sro, m_lo, m_ao}, 32'd0);
      checkOutput("rst_main_flags", {29'd0, m_busy, m_done, m_pass}, 32'd0);
      checkOutput("rst_main_sig", m_sig, 32'd0);
      checkOutput("rst_main_cnt", {16'd0, m_cnt}, 32'd0);
      checkOutput("rst_seq_a", s_a, 32'd1);
      checkOutput("rst_others_ops", {p_as, p_sro, p_lo, p_ao, f_as, f_sro, f_lo, f_ao, 4'd0}, 32'd0);
      checkOutput("rst_n1_ops", {18'd0, o_as, o_sro, o_lo, o_ao}, 32'd0);
      checkOutput("rst_others_a", p_a ^ f_a ^ o_a, SA);
      checkOutput("rst_others_b", p_b ^ f_b ^ o_b, SB);
      @(negedge clk);
      rst_n = 1'b1;

      // Opcode sweep and first operand step on the SEED_A=1 instance
      applyStimulus(5'b00010);
      for (int k = 0; k < 16; k++) begin
         checkOutput("seq_op_index", {28'd0, tbl[k].op}, 32'(k));
         checkOutput("seq_as", {28'd0, s_as}, {28'd0, tbl[k].as_v});
         checkOutput("seq_sro", {28'd0, s_sro}, {28'd0, tbl[k].sro_v});
         checkOutput("seq_lo", {28'd0, s_lo}, {28'd0, tbl[k].lo_v});
         checkOutput("seq_ao", {30'd0, s_ao}, {30'd0, tbl[k].ao_v});
         checkOutput("seq_a_held", s_a, 32'd1);
         @(negedge clk);
      end
      checkOutput("seq_a_step", s_a, 32'h8020_0003);
      checkOutput("seq_b_step", s_b, lfsr_step(SB));
      checkOutput("seq_ops_wrap", {18'd0, s_as, s_sro, s_lo, s_ao}, 32'd0);
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         if (s_done) hit = 1'b1;
         else @(negedge clk);
      end
      checkOutput("seq_done_timeout", {31'd0, hit}, 32'd1);
      checkOutput("seq_cnt", {16'd0, s_cnt}, 32'(SEQ_N));
      checkOutput("seq_sig", s_sig, ref_seq);
      checkOutput("seq_pass", {31'd0, s_pass}, {31'd0, ref_seq == 32'd0});
      checkOutput("seq_busy", {31'd0, s_busy}, 32'd0);

      // N=4 pass/fail pair and N=1 boundary, run twice; start pulses mid-run ignored
      for (int run = 0; run < 2; run++) begin
         applyStimulus(5'b11100);
         for (int c = 1; c <= 4; c++) begin
            start_v[2] = (c == 1) || (c == 2);
            @(negedge clk);
            if (c < 4) begin
               checkOutput("n4_busy_mid", {30'd0, p_busy, f_busy}, 32'd3);
               checkOutput("n4_done_mid", {30'd0, p_done, f_done}, 32'd0);
               checkOutput("n4_cnt_mid", {16'd0, p_cnt}, 32'(c));
            end
            if (c == 1) begin
               checkOutput("n1_done", {31'd0, o_done}, 32'd1);
               checkOutput("n1_busy", {31'd0, o_busy}, 32'd0);
               checkOutput("n1_cnt", {16'd0, o_cnt}, 32'd1);
               checkOutput("n1_sig", o_sig, ref_one);
               checkOutput("n1_pass", {31'd0, o_pass}, {31'd0, ref_one == 32'd0});
            end
         end
         start_v = 5'd0;
         checkOutput("n4p_done", {31'd0, p_done}, 32'd1);
         checkOutput("n4p_busy", {31'd0, p_busy}, 32'd0);
         checkOutput("n4p_cnt", {16'd0, p_cnt}, 32'd4);
         checkOutput("n4p_sig", p_sig, GOLD4);
         checkOutput("n4p_pass", {31'd0, p_pass}, 32'd1);
         checkOutput("n4f_sig", f_sig, GOLD4);
         checkOutput("n4f_pass", {31'd0, f_pass}, 32'd0);
         checkOutput("n4f_done", {31'd0, f_done}, 32'd1);
         checkOutput("n1_cnt_hold", {16'd0, o_cnt}, 32'd1);
         checkOutput("n1_sig_hold", o_sig, ref_one);
      end

      // Main instance: uninterrupted run, then a repeat from DONE
      checkRunMain(ref_main);
      checkRunMain(ref_main);

      // Mid-run reset at vec_count=100, asserted between clock edges
      applyStimulus(5'b00001);
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         if (m_cnt == 16'd100) hit = 1'b1;
         else @(negedge clk);
      end
      checkOutput("mid_reach_100", {31'd0, hit}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_flags", {29'd0, m_busy, m_done, m_pass}, 32'd0);
      checkOutput("mid_rst_cnt", {16'd0, m_cnt}, 32'd0);
      checkOutput("mid_rst_sig", m_sig, 32'd0);
      checkOutput("mid_rst_a", m_a, SA);
      checkOutput("mid_rst_b", m_b, SB);
      checkOutput("mid_rst_ops", {18'd0, m_as, m_sro, m_lo, m_ao}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      checkRunMain(ref_main);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
